seq_divider: RTL and testbench

- Sequential signed two's-complement divider. It is the inverse companion of the team's combinational tree multiplier in the ALU datapath.
- Computes quotient and remainder of A / B with restoring division, one quotient bit per clock.
- Start/busy/done handshake. Results are held stable until the next accepted start.
- Sits beside the multiplier in the integer ALU. The ALU sequencer issues operations and waits on done.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 162 ++++++++++++++++
 tb/tb_seq_divider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared ALU definitions for the sequential divider: default width, FSM encoding
// and the most-negative operand constant.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] MOST_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit and
// subtract the divisor magnitude when it fits.
module seq_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_in, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};

    // rem_in is always below the divisor, so shifted stays below 2^WIDTH and the
    // top bit of the difference is a clean borrow flag.
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed two's-complement divider: restoring division on magnitudes,
// one quotient bit per clock, sign fix-up afterwards, start/busy/done handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DVZ,
    output logic             OVF,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state;
    div_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] mag_b;
    logic             sign_q;
    logic             sign_r;
    logic             ovf_pend;

    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // Start is only looked at when no operation is in flight, which includes the
    // DONE cycle so the sequencer can issue back-to-back.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign div_zero = (B == '0);

    // Negating the most-negative value wraps back to itself, which read as
    // unsigned is exactly 2^(WIDTH-1).
    assign mag_a_in = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign mag_b_in = B[WIDTH-1] ? (~B + 1'b1) : B;

    seq_divider_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_in (rem),
        .dvd_bit(dvd[WIDTH-1]),
        .divisor(mag_b),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_next = div_zero ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Quotient bits shift into the low end of dvd as dividend bits leave the top,
    // so after WIDTH steps dvd holds the quotient magnitude.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            mag_b    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            ovf_pend <= 1'b0;
            Q        <= '0;
            R        <= '0;
            DVZ      <= 1'b0;
            OVF      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        cnt      <= '0;
                        rem      <= '0;
                        dvd      <= mag_a_in;
                        mag_b    <= mag_b_in;
                        sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r   <= A[WIDTH-1];
                        ovf_pend <= (A == MIN_VAL) && (B == '1);
                        if (div_zero) begin
                            Q   <= '1;
                            R   <= A;
                            DVZ <= 1'b1;
                            OVF <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[WIDTH-2:0], step_q};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    DVZ <= 1'b0;
                    if (ovf_pend) begin
                        Q   <= MIN_VAL;
                        R   <= '0;
                        OVF <= 1'b1;
                    end else begin
                        Q   <= sign_q ? (~dvd + 1'b1) : dvd;
                        R   <= sign_r ? (~rem + 1'b1) : rem;
                        OVF <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake/corner cases plus
// randomized operands against a C-truncation arithmetic model.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W       = 32;
    localparam int NORM_LAT = W + 2;
    localparam int DVZ_LAT  = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         DVZ;
    logic         OVF;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .Q    (Q),
        .R    (R),
        .DVZ  (DVZ),
        .OVF  (OVF),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed division with C truncation semantics.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dvz, output logic ovf);
        longint sa;
        longint sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dvz = 1'b0;
        ovf = 1'b0;
        if (sb == 0) begin
            q   = '1;
            r   = a;
            dvz = 1'b1;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
            if (sa == -(64'sd1 <<< (W - 1)) && sb == -1) ovf = 1'b1;
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge (cycle c0).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int c0);
        c0    = cyc;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int lat, output int busy_hi);
        lat     = -1;
        busy_hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                lat = cyc - c0;
                break;
            end
            if (busy) busy_hi++;
            @(negedge clk);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return MOST_NEG;
            4:       return 32'h7FFF_FFFF;
            5:       return W'($urandom_range(0, 40)) - W'(20);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic run_checked(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eq, er;
        logic         edvz, eovf;
        int           c0, lat, bh;
        model(a, b, eq, er, edvz, eovf);
        issue(a, b, c0);
        wait_done(c0, lat, bh);
        check({tag, ".lat"}, 64'(lat), 64'((b == '0) ? DVZ_LAT : NORM_LAT));
        check({tag, ".Q"}, 64'(Q), 64'(eq));
        check({tag, ".R"}, 64'(R), 64'(er));
        check({tag, ".DVZ"}, 64'(DVZ), 64'(edvz));
        check({tag, ".OVF"}, 64'(OVF), 64'(eovf));
    endtask

    initial begin
        int c0, c1, lat, bh, dones;
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst.Q", 64'(Q), 64'd0);
        check("rst.R", 64'(R), 64'd0);
        check("rst.flags", 64'({DVZ, OVF, busy, done}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic operation with exact latency and busy window.
        issue(32'd100, 32'd7, c0);
        wait_done(c0, lat, bh);
        check("basic.lat", 64'(lat), 64'(NORM_LAT));
        check("basic.busy_cycles", 64'(bh), 64'(NORM_LAT - 1));
        check("basic.busy_at_done", 64'(busy), 64'd0);
        check("basic.Q", 64'(Q), 64'd14);
        check("basic.R", 64'(R), 64'd2);
        check("basic.flags", 64'({DVZ, OVF}), 64'd0);
        @(negedge clk);
        check("basic.done_pulse", 64'(done), 64'd0);
        check("basic.hold_Q", 64'(Q), 64'd14);

        // Sign combinations.
        issue(-32'sd100, 32'd7, c0);
        wait_done(c0, lat, bh);
        check("nA.Q", 64'(Q), 64'hFFFF_FFF2);
        check("nA.R", 64'(R), 64'hFFFF_FFFE);
        issue(32'd100, -32'sd7, c0);
        wait_done(c0, lat, bh);
        check("nB.Q", 64'(Q), 64'hFFFF_FFF2);
        check("nB.R", 64'(R), 64'd2);
        issue(-32'sd100, -32'sd7, c0);
        wait_done(c0, lat, bh);
        check("nAB.Q", 64'(Q), 64'd14);
        check("nAB.R", 64'(R), 64'hFFFF_FFFE);

        // Divide by zero and overflow.
        issue(32'd5, 32'd0, c0);
        wait_done(c0, lat, bh);
        check("dvz.lat", 64'(lat), 64'(DVZ_LAT));
        check("dvz.Q", 64'(Q), 64'hFFFF_FFFF);
        check("dvz.R", 64'(R), 64'd5);
        check("dvz.flags", 64'({DVZ, OVF}), 64'b10);
        issue(MOST_NEG, 32'hFFFF_FFFF, c0);
        wait_done(c0, lat, bh);
        check("ovf.lat", 64'(lat), 64'(NORM_LAT));
        check("ovf.Q", 64'(Q), 64'h8000_0000);
        check("ovf.R", 64'(R), 64'd0);
        check("ovf.flags", 64'({DVZ, OVF}), 64'b01);
        @(negedge clk);

        // Start while busy is ignored; start in the DONE cycle is accepted.
        issue(32'd100, 32'd7, c0);
        repeat (3) @(negedge clk);
        A     = 32'd9;
        B     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c0, lat, bh);
        check("ign.lat", 64'(lat), 64'(NORM_LAT));
        check("ign.Q", 64'(Q), 64'd14);
        check("ign.R", 64'(R), 64'd2);
        issue(32'd9, 32'd3, c1);
        check("b2b.hold_Q", 64'(Q), 64'd14);
        wait_done(c1, lat, bh);
        check("b2b.abs_lat", 64'(cyc - c0), 64'(2 * NORM_LAT));
        check("b2b.Q", 64'(Q), 64'd3);
        check("b2b.R", 64'(R), 64'd0);
        @(negedge clk);

        // Reset mid-operation aborts with no done pulse.
        issue(32'd1000, 32'd3, c0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.cycle", 64'(cyc - c0), 64'd11);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.Q", 64'(Q), 64'd0);
        check("abort.R", 64'(R), 64'd0);
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort.no_done", 64'(dones), 64'd0);
        issue(32'd1000, 32'd3, c0);
        wait_done(c0, lat, bh);
        check("post_rst.lat", 64'(lat), 64'(NORM_LAT));
        check("post_rst.Q", 64'(Q), 64'd333);
        check("post_rst.R", 64'(R), 64'd1);

        // Randomized operands, mixing back-to-back and idle gaps.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_checked(pick(), pick(), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
